uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Configurable UART receiver for the FPGA demo designs. Runtime baud divisor,
//  parametrised frame format (data bits, parity, stop bits) and oversampling.
//  3-sample majority vote at mid-bit. Reports parity, framing and break errors.
//  Holds each received word in a valid/ready register and flags overrun.
// PARAMETERS
//  OVERSAMPLE  16  sample ticks per bit; even, 8..32
//  DATA_BITS   8   data bits per frame; 5..8; rx_data upper bits read 0
//  PARITY      0   0=none, 1=odd, 2=even
//  STOP_BITS   1   1 or 2; every stop bit is checked
//  DIV_W       16  width of cfg_baud_div
// PORTS
//  clk_rx        in   1      system clock
//  rst_clk_rx    in   1      reset, asynchronous, active-high
//  rxd_i         in   1      RS232 RXD, straight from the pad (asynchronous)
//  cfg_baud_div  in   DIV_W  clk_rx cycles per sample tick, minus 1 (>=1)
//  rx_data       out  8      received word, LSB = first data bit
//  rx_valid      out  1      rx_data and the error flags are valid
//  rx_ready      in   1      consumer accepts the word when rx_valid&rx_ready
//  par_err       out  1      parity mismatch for the held word
//  frm_err       out  1      a stop bit sampled 0 for the held word
//  brk_det       out  1      break: all data, parity and stop bits 0
//  overrun       out  1      sticky; a frame was lost while rx_valid was high
// BEHAVIOUR
//  Reset: all outputs 0. FSM in IDLE. Tick counter and divisor counter at 0.
//  rxd_i goes through meta_harden (2 FFs). All sampling uses the hardened bit.
//  Tick generator: counts 0..div; tick pulse when count==div, then reloads.
//   div is latched from cfg_baud_div on each IDLE->START. A change mid-frame
//   has no effect. The counter is held at 0 in IDLE.
//  Majority vote: samples at ticks OVERSAMPLE/2-1, /2, /2+1 of each bit
//   period; bit value = 2-of-3.
//  FSM: IDLE -> START on a falling edge of the hardened line.
//   START: if the voted value is 1, treat as a glitch and return to IDLE with
//    no outputs changed. Otherwise go to DATA at the end of the bit period.
//   DATA: DATA_BITS bits, shifted in LSB first. Then PARITY if PARITY!=0,
//    otherwise STOP.
//   PARITY: compare with the computed odd/even parity of the data bits.
//   STOP: STOP_BITS periods. frm_err_int |= ~bit. Go to DONE after the middle
//    sample of the last stop bit, not the end of the bit, so back-to-back
//    frames are not missed.
//   DONE (1 cycle): commit to the holding register, then IDLE. IDLE requires
//    the line high before a new falling edge counts (line held low = no retrigger).
//  Holding register: on DONE with rx_valid=0, load data and flags and set
//   rx_valid. On DONE with rx_valid=1, set overrun and drop the new frame
//   (old word kept). A DONE in the same cycle as the handshake loads the new
//   word and does not set overrun.
//  rx_valid clears on the cycle after rx_valid&rx_ready unless a new word loads.
//  overrun clears only on a handshake or on reset.
//  brk_det=1 implies frm_err=1. par_err is always 0 when PARITY=0.
//  Reset mid-frame: asynchronous clear. No partial word is ever presented.
//  Latency: rx_valid rises 2 clk_rx after the mid-sample of the last stop bit.
// STRUCTURE
//  uart_pkg: parity encodings (PAR_NONE/ODD/EVEN), FSM state enum
//   (IDLE, START, DATA, PARITY, STOP, DONE), and OVERSAMPLE range checks.
//  Sub-module uart_tick_gen: runtime divisor, enable input, tick output.
//   meta_harden is reused unchanged.
//  Elaboration-time error on illegal parameter combinations.
// TESTING (CLOCK 40 MHz, cfg_baud_div=21 => 115200 baud @16x)
//  1. 8N1, send 0xA5 with rx_ready=1 -> rx_valid pulse, rx_data=0xA5,
//     all error flags 0.
//  2. PARITY=2, send 0x5A with parity bit 1 -> rx_data=0x5A, par_err=1;
//     repeat with the correct parity bit 0 -> par_err=0.
//  3. Line low for 3 ticks, then high -> no rx_valid; the next frame 0x3C
//     received intact.
//  4. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1;
//     assert rx_ready -> rx_valid and overrun clear.
//  5. Line low for 12 bit times -> brk_det=1, frm_err=1, rx_data=0x00;
//     only one frame is reported.
//  6. Assert rst_clk_rx in the middle of data bit 4 -> all outputs 0
//     immediately; after release, 0xC3 received correctly.
//  Also: 2 stop bits with the second stop bit 0 -> frm_err=1. Change
//  cfg_baud_div mid-frame -> that frame is unaffected.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : uart_pkg
//  Description: Shared parity encodings, receiver FSM states and helpers.
//  Revision   : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int OS_MIN = 8;
    localparam int OS_MAX = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    function automatic bit os_legal(input int os);
        return (os >= OS_MIN) && (os <= OS_MAX) && ((os % 2) == 0);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/meta_harden.sv
`default_nettype none
// ============================================================================
//  Module     : meta_harden
//  Description: Two-flop synchroniser for an asynchronous single-bit input.
//  Revision   : 1.0  initial release
// ============================================================================
module meta_harden (
    input  logic clk_dst,
    input  logic rst_dst,
    input  logic signal_src,
    output logic signal_dst
);

    logic signal_meta_q;
    logic signal_dst_q;

    // Resets to the idle-high line level so reset release is not seen as a start edge
    always_ff @(posedge clk_dst or posedge rst_dst) begin
        if (rst_dst) begin
            signal_meta_q <= 1'b1;
            signal_dst_q  <= 1'b1;
        end else begin
            signal_meta_q <= signal_src;
            signal_dst_q  <= signal_meta_q;
        end
    end

    assign signal_dst = signal_dst_q;

endmodule
`default_nettype wire

// File: rtl/uart_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module     : uart_tick_gen
//  Description: Runtime-divisor sample tick generator, held at 0 when disabled.
//  Revision   : 1.0  initial release
// ============================================================================
module uart_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == div_i);
        cnt_d  = cnt_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module     : uart_rx_cfg
//  Description: Configurable oversampling UART receiver with majority vote,
//               error flags and a valid/ready holding register.
//  Revision   : 1.0  initial release
// ============================================================================
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic             clk_rx,
    input  logic             rst_clk_rx,
    input  logic             rxd_i,
    input  logic [DIV_W-1:0] cfg_baud_div,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             par_err,
    output logic             frm_err,
    output logic             brk_det,
    output logic             overrun
);

    if (!os_legal(OVERSAMPLE)) begin : g_chk_os
        $error("uart_rx_cfg: OVERSAMPLE must be even and within 8..32");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_chk_db
        $error("uart_rx_cfg: DATA_BITS must be within 5..8");
    end
    if ((PARITY < PAR_NONE) || (PARITY > PAR_EVEN)) begin : g_chk_par
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_chk_stop
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (DIV_W < 1) begin : g_chk_div
        $error("uart_rx_cfg: DIV_W must be at least 1");
    end

    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam logic [SAMP_W-1:0] SMP_LO    = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SMP_MID   = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] SMP_HI    = SAMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMP_W-1:0] SMP_END   = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    logic rxd_s;
    logic tick;
    logic tick_en;
    logic voted;
    logic bit_done;
    logic bit_end;
    logic par_exp;
    logic handshake;

    state_e                 state_q,   state_d;
    logic [DIV_W-1:0]       div_q,     div_d;
    logic [SAMP_W-1:0]      samp_q,    samp_d;
    logic [1:0]             vote_q,    vote_d;
    logic [2:0]             bitc_q,    bitc_d;
    logic                   stopc_q,   stopc_d;
    logic [DATA_BITS-1:0]   shift_q,   shift_d;
    logic                   par_e_q,   par_e_d;
    logic                   frm_e_q,   frm_e_d;
    logic                   seen1_q,   seen1_d;
    logic                   rxd_prev_q;
    logic [7:0]             data_q,    data_d;
    logic                   valid_q,   valid_d;
    logic                   pe_q,      pe_d;
    logic                   fe_q,      fe_d;
    logic                   bd_q,      bd_d;
    logic                   ovr_q,     ovr_d;

    meta_harden u_meta (
        .clk_dst    (clk_rx),
        .rst_dst    (rst_clk_rx),
        .signal_src (rxd_i),
        .signal_dst (rxd_s)
    );

    assign tick_en = (state_q != ST_IDLE) && (state_q != ST_DONE);

    uart_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk_i  (clk_rx),
        .rst_i  (rst_clk_rx),
        .en_i   (tick_en),
        .div_i  (div_q),
        .tick_o (tick)
    );

    // Two samples are stored; the third is the live line at the last vote tick
    assign voted     = maj3(vote_q[1], vote_q[0], rxd_s);
    assign bit_done  = tick && (samp_q == SMP_HI);
    assign bit_end   = tick && (samp_q == SMP_END);
    assign par_exp   = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;
    assign handshake = valid_q & rx_ready;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        samp_d  = samp_q;
        vote_d  = vote_q;
        bitc_d  = bitc_q;
        stopc_d = stopc_q;
        shift_d = shift_q;
        par_e_d = par_e_q;
        frm_e_d = frm_e_q;
        seen1_d = seen1_q;

        if (tick) begin
            samp_d = (samp_q == SMP_END) ? '0 : samp_q + 1'b1;
            if ((samp_q == SMP_LO) || (samp_q == SMP_MID)) begin
                vote_d = {vote_q[0], rxd_s};
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rxd_prev_q && !rxd_s) begin
                    state_d = ST_START;
                    div_d   = cfg_baud_div;
                    samp_d  = '0;
                    bitc_d  = '0;
                    stopc_d = 1'b0;
                    par_e_d = 1'b0;
                    frm_e_d = 1'b0;
                    seen1_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done && voted) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = {voted, shift_q[DATA_BITS-1:1]};
                    seen1_d = seen1_q | voted;
                end
                if (bit_end) begin
                    if (bitc_q == LAST_BIT) begin
                        bitc_d  = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bitc_d = bitc_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    par_e_d = voted ^ par_exp;
                    seen1_d = seen1_q | voted;
                end
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at the vote of the last stop bit so a back-to-back start edge is caught
                if (bit_done) begin
                    frm_e_d = frm_e_q | ~voted;
                    seen1_d = seen1_q | voted;
                    if (stopc_q == LAST_STOP) begin
                        state_d = ST_DONE;
                    end else begin
                        stopc_d = stopc_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        bd_d    = bd_q;
        ovr_d   = ovr_q;

        if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (state_q == ST_DONE) begin
            if (!valid_q || handshake) begin
                valid_d = 1'b1;
                data_d  = 8'(shift_q);
                pe_d    = par_e_q;
                fe_d    = frm_e_q;
                bd_d    = ~seen1_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            samp_q     <= '0;
            vote_q     <= '0;
            bitc_q     <= '0;
            stopc_q    <= 1'b0;
            shift_q    <= '0;
            par_e_q    <= 1'b0;
            frm_e_q    <= 1'b0;
            seen1_q    <= 1'b0;
            rxd_prev_q <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            bd_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            samp_q     <= samp_d;
            vote_q     <= vote_d;
            bitc_q     <= bitc_d;
            stopc_q    <= stopc_d;
            shift_q    <= shift_d;
            par_e_q    <= par_e_d;
            frm_e_q    <= frm_e_d;
            seen1_q    <= seen1_d;
            rxd_prev_q <= rxd_s;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            bd_q       <= bd_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign par_err  = pe_q;
    assign frm_err  = fe_q;
    assign brk_det  = bd_q;
    assign overrun  = ovr_q;

endmodule
`default_nettype wire
